// File: rtl/seq1010_pkg.sv
// Shared types and constants for the 1010 framer and its line-state tracker.
// The tracker step function mirrors the receive-side non-overlapping detector.
package seq1010_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    DATA  = 3'd2,
    STUFF = 3'd3,
    GUARD = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } shadow_t;

  localparam logic [3:0] PREAMBLE = 4'b1010;
  localparam int         PRE_LEN  = 4;

  // S3 followed by 0 is a detector match; the detector restarts from S0.
  function automatic shadow_t shadow_step(input shadow_t s, input logic b);
    shadow_t r;
    r = S0;
    unique case (s)
      S0: r = b ? S1 : S0;
      S1: r = b ? S1 : S2;
      S2: r = b ? S3 : S0;
      S3: r = b ? S1 : S0;
      default: r = S0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seq1010_shadow.sv
// Copy of the receiver's 1010 detector state, stepped by each bit put on the line.
// Clear has priority so the preamble match can restart the tracker.
module seq1010_shadow
  import seq1010_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    advance,
  input  logic    bit_in,
  input  logic    clear,
  output shadow_t state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
    end else if (clear) begin
      state <= S0;
    end else if (advance) begin
      state <= shadow_step(state, bit_in);
    end
  end

endmodule

// File: rtl/seq1010_framer_tx.sv
// Transmit framer: preamble 1010, payload MSB-first with 1-stuffing after "101",
// then a zero guard, so a non-overlapping 1010 detector matches once per frame.
module seq1010_framer_tx
  import seq1010_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GUARD_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_active,
  output logic              tx_stuff
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int GCNT_W = $clog2(GUARD_BITS + 1);

  state_t              state;
  state_t              state_nxt;
  shadow_t             shadow;
  shadow_t             data_shadow;
  logic [DATA_W-1:0]   shift_q;
  logic [CNT_W-1:0]    bit_cnt;
  logic [1:0]          pre_idx;
  logic [1:0]          pre_pos;
  logic [GCNT_W-1:0]   guard_cnt;
  logic                bit_nxt;
  logic                active_nxt;
  logic                stuff_nxt;
  logic                consume;
  logic                last_bit;
  logic                pre_last;
  logic                clear_shadow;

  assign in_ready     = (state == IDLE);
  assign last_bit     = (bit_cnt == CNT_W'(1));
  assign pre_last     = (pre_idx == 2'(PRE_LEN - 1));
  assign pre_pos      = 2'(PRE_LEN - 1) - pre_idx;
  assign clear_shadow = (state == PRE) && pre_last;
  // Tracker state once the current payload MSB is on the line.
  assign data_shadow  = shadow_step(shadow, shift_q[DATA_W-1]);

  seq1010_shadow u_shadow (
    .clk     (clk),
    .rst     (rst),
    .advance (state != IDLE),
    .bit_in  (bit_nxt),
    .clear   (clear_shadow),
    .state   (shadow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) state_nxt = PRE;
      end
      PRE: begin
        if (pre_last) state_nxt = DATA;
      end
      DATA: begin
        if (shadow == S3) begin
          state_nxt = DATA;
        end else if (data_shadow == S3) begin
          state_nxt = STUFF;
        end else if (last_bit) begin
          state_nxt = GUARD;
        end else begin
          state_nxt = DATA;
        end
      end
      STUFF: begin
        state_nxt = (bit_cnt == '0) ? GUARD : DATA;
      end
      GUARD: begin
        if (guard_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stuffing is normally scheduled ahead via data_shadow; the shadow==S3 arm
  // in DATA is a fallback that stuffs in place without consuming a bit.
  always_comb begin
    bit_nxt    = 1'b0;
    active_nxt = 1'b0;
    stuff_nxt  = 1'b0;
    consume    = 1'b0;
    unique case (state)
      IDLE: ;
      PRE: begin
        bit_nxt    = PREAMBLE[pre_pos];
        active_nxt = 1'b1;
      end
      DATA: begin
        active_nxt = 1'b1;
        if (shadow == S3) begin
          bit_nxt   = 1'b1;
          stuff_nxt = 1'b1;
        end else begin
          bit_nxt = shift_q[DATA_W-1];
          consume = 1'b1;
        end
      end
      STUFF: begin
        bit_nxt    = 1'b1;
        active_nxt = 1'b1;
        stuff_nxt  = 1'b1;
      end
      GUARD: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_bit    <= 1'b0;
      tx_active <= 1'b0;
      tx_stuff  <= 1'b0;
    end else begin
      tx_bit    <= bit_nxt;
      tx_active <= active_nxt;
      tx_stuff  <= stuff_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt   <= '0;
      pre_idx   <= '0;
      guard_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shift_q   <= in_data;
            bit_cnt   <= CNT_W'(DATA_W);
            pre_idx   <= '0;
            guard_cnt <= GCNT_W'(GUARD_BITS - 1);
          end
        end
        PRE: begin
          pre_idx <= pre_idx + 2'd1;
        end
        DATA: begin
          if (consume) begin
            shift_q <= shift_q << 1;
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        GUARD: begin
          guard_cnt <= guard_cnt - GCNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
